// File: rtl/gpio_link_responder.sv
// Board-side responder for the bit-banged GPIO header: synchronizes the header lines, runs a
// four-phase req/ack handshake and services a small 24-bit register file.
module gpio_link_responder #(
    parameter int NUM_REGS      = 16,
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [35:0] gpio_in,
    output logic [35:0] gpio_out,
    input  logic [3:0]  local_addr,
    output logic [23:0] local_rdata,
    output logic        wr_pulse,
    output logic [7:0]  wr_addr,
    output logic [23:0] wr_data,
    output logic [15:0] txn_count
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SETTLE, EXEC, ACK} state_t;

    logic [SYNC_STAGES-1:0][35:0] sync_q;
    logic [SYNC_STAGES-1:0]       fill_q;
    logic [35:0]                  sync_out;
    logic                         sync_ready;
    logic                         req_s;
    logic                         we_s;
    logic [7:0]                   addr_s;
    logic [23:0]                  wdata_s;
    logic                         addr_ok;
    logic                         local_ok;
    logic                         unused_hdr_bits;

    state_t            state;
    logic              armed;
    logic [CNT_W-1:0]  settle_cnt;
    logic [23:0]       rdata;
    logic              ack;
    logic              err;
    logic              busy;
    logic [23:0]       regs [NUM_REGS];

    // fill_q marks when the last sync stage holds real header data rather than its reset zeros,
    // so a req held high across reset is never mistaken for a low level.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            fill_q <= '0;
        end else begin
            sync_q[0] <= gpio_in;
            fill_q[0] <= 1'b1;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
                fill_q[i] <= fill_q[i-1];
            end
        end
    end

    assign sync_out        = sync_q[SYNC_STAGES-1];
    assign sync_ready      = fill_q[SYNC_STAGES-1];
    assign wdata_s         = sync_out[23:0];
    assign addr_s          = sync_out[31:24];
    assign we_s            = sync_out[32];
    assign req_s           = sync_out[33];
    assign unused_hdr_bits = ^sync_out[35:34];

    assign addr_ok  = 32'(addr_s) < NUM_REGS;
    assign local_ok = 32'(local_addr) < NUM_REGS;

    // A write in flight lands on the edge, so a same-cycle local read still sees the old value.
    assign local_rdata = local_ok ? regs[local_addr[IDX_W-1:0]] : '0;
    assign gpio_out    = {1'b0, busy, err, ack, 8'h00, rdata};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            armed      <= 1'b0;
            settle_cnt <= '0;
            rdata      <= '0;
            ack        <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
            wr_pulse   <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            txn_count  <= '0;
            // NOTE: the register file is small and must read back zero after reset, so it is
            // built from resettable flops rather than a RAM macro.
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            wr_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (!req_s) begin
                        if (sync_ready) armed <= 1'b1;
                    end else if (armed) begin
                        state      <= SETTLE;
                        settle_cnt <= CNT_W'(SETTLE_CYCLES - 1);
                        busy       <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (!req_s) begin
                        state      <= IDLE;
                        settle_cnt <= '0;
                        busy       <= 1'b0;
                    end else if (settle_cnt == '0) begin
                        state <= EXEC;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                EXEC: begin
                    if (!addr_ok) begin
                        err   <= 1'b1;
                        rdata <= '0;
                    end else if (we_s) begin
                        regs[addr_s[IDX_W-1:0]] <= wdata_s;
                        rdata    <= wdata_s;
                        err      <= 1'b0;
                        wr_pulse <= 1'b1;
                        wr_addr  <= addr_s;
                        wr_data  <= wdata_s;
                    end else begin
                        rdata <= regs[addr_s[IDX_W-1:0]];
                        err   <= 1'b0;
                    end
                    txn_count <= txn_count + 1'b1;
                    ack       <= 1'b1;
                    state     <= ACK;
                end
                ACK: begin
                    if (!req_s) begin
                        state <= IDLE;
                        ack   <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_link_responder.sv
// Directed bench for gpio_link_responder: handshake latency, write/read, error, glitch,
// reset-related behaviour and transaction counter wrap.
module tb_gpio_link_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [35:0] gpio_in;
    logic [35:0] gpio_out;
    logic [3:0]  local_addr;
    logic [23:0] local_rdata;
    logic        wr_pulse;
    logic [7:0]  wr_addr;
    logic [23:0] wr_data;
    logic [15:0] txn_count;

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_cnt = 0;
    int ack_cycles = 0;

    gpio_link_responder dut (
        .clk        (clk),
        .rst        (rst),
        .gpio_in    (gpio_in),
        .gpio_out   (gpio_out),
        .local_addr (local_addr),
        .local_rdata(local_rdata),
        .wr_pulse   (wr_pulse),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .txn_count  (txn_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_pulse) pulse_cnt++;
        if (gpio_out[32]) ack_cycles++;
    end

    initial begin
        #2ms;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Full handshake: raise req, wait for ack, capture results, drop req, wait for ack to fall.
    task automatic do_txn(input logic [7:0] a, input logic w, input logic [23:0] d,
                          output logic [23:0] rd, output logic er, output logic wp);
        int lat;
        int drop;
        gpio_in = {2'b00, 1'b1, w, a, d};
        lat = 0;
        do begin
            step(1);
            lat++;
        end while (!gpio_out[32] && lat < 40);
        check("ack_latency", 36'(lat), 36'd8);
        check("busy_in_ack", 36'(gpio_out[34]), 36'd1);
        rd = gpio_out[23:0];
        er = gpio_out[33];
        wp = wr_pulse;
        gpio_in[33] = 1'b0;
        drop = 0;
        do begin
            step(1);
            drop++;
        end while (gpio_out[32] && drop < 40);
        check("ack_drop_latency", 36'(drop), 36'd3);
        check("busy_after_drop", 36'(gpio_out[34]), 36'd0);
    endtask

    initial begin
        logic [23:0] rd;
        logic        er;
        logic        wp;
        int          p0;
        int          a0;

        rst        = 1'b1;
        gpio_in    = '0;
        local_addr = 4'd0;
        step(3);
        check("reset_gpio_out", gpio_out, 36'h0);
        check("reset_txn_count", 36'(txn_count), 36'h0);
        check("reset_wr_pulse", 36'(wr_pulse), 36'h0);
        rst = 1'b0;
        step(5);

        // Write 0xABCDEF to register 3, then read it back.
        p0 = pulse_cnt;
        do_txn(8'h03, 1'b1, 24'hABCDEF, rd, er, wp);
        check("wr_echo_rdata", 36'(rd), 36'hABCDEF);
        check("wr_err", 36'(er), 36'h0);
        check("wr_pulse_at_ack", 36'(wp), 36'h1);
        check("wr_pulse_count", 36'(pulse_cnt - p0), 36'd1);
        check("wr_addr", 36'(wr_addr), 36'h03);
        check("wr_data", 36'(wr_data), 36'hABCDEF);
        do_txn(8'h03, 1'b0, 24'h000000, rd, er, wp);
        check("rd_rdata", 36'(rd), 36'hABCDEF);
        check("rd_err", 36'(er), 36'h0);
        local_addr = 4'd3;
        #1;
        check("local_rdata_3", 36'(local_rdata), 36'hABCDEF);
        check("txn_count_2", 36'(txn_count), 36'd2);

        // Out-of-range address reports an error and leaves the register file alone.
        p0 = pulse_cnt;
        do_txn(8'h10, 1'b1, 24'h123456, rd, er, wp);
        check("bad_err", 36'(er), 36'h1);
        check("bad_rdata", 36'(rd), 36'h0);
        check("bad_no_pulse", 36'(pulse_cnt - p0), 36'd0);
        check("bad_wr_addr_held", 36'(wr_addr), 36'h03);
        check("bad_reg3_kept", 36'(local_rdata), 36'hABCDEF);
        check("bad_txn_count", 36'(txn_count), 36'd3);
        check("rdata_held_idle", 36'(gpio_out[23:0]), 36'h0);
        check("err_held_idle", 36'(gpio_out[33]), 36'h1);

        // req high for only three clocks: settle aborts, nothing executes.
        a0 = ack_cycles;
        gpio_in = {2'b00, 1'b1, 1'b1, 8'h04, 24'h777777};
        step(3);
        check("glitch_busy_high", 36'(gpio_out[34]), 36'h1);
        gpio_in[33] = 1'b0;
        step(3);
        check("glitch_busy_low", 36'(gpio_out[34]), 36'h0);
        step(10);
        check("glitch_no_ack", 36'(ack_cycles - a0), 36'd0);
        check("glitch_txn_count", 36'(txn_count), 36'd3);
        local_addr = 4'd4;
        #1;
        check("glitch_reg4_untouched", 36'(local_rdata), 36'h0);

        // req held high across reset release must not start a transaction.
        rst = 1'b1;
        gpio_in = {2'b00, 1'b1, 1'b0, 8'h03, 24'h0};
        step(3);
        rst = 1'b0;
        a0 = ack_cycles;
        step(20);
        check("rstreq_no_ack", 36'(ack_cycles - a0), 36'd0);
        check("rstreq_not_busy", 36'(gpio_out[34]), 36'h0);
        gpio_in[33] = 1'b0;
        step(4);
        do_txn(8'h03, 1'b0, 24'h0, rd, er, wp);
        check("rstreq_reg3_cleared", 36'(rd), 36'h0);
        check("rstreq_txn_count", 36'(txn_count), 36'd1);

        // Reset during SETTLE of a write aborts it.
        do_txn(8'h05, 1'b1, 24'h111111, rd, er, wp);
        check("pre_mid_txn_count", 36'(txn_count), 36'd2);
        gpio_in = {2'b00, 1'b1, 1'b1, 8'h05, 24'h555555};
        step(4);
        check("mid_busy_before_rst", 36'(gpio_out[34]), 36'h1);
        rst = 1'b1;
        #1;
        check("mid_gpio_out", gpio_out, 36'h0);
        gpio_in = '0;
        step(2);
        rst = 1'b0;
        step(12);
        local_addr = 4'd5;
        #1;
        check("mid_reg5_zero", 36'(local_rdata), 36'h0);
        check("mid_gpio_out_idle", gpio_out, 36'h0);
        check("mid_txn_count", 36'(txn_count), 36'd0);

        // Same-cycle local read / header write: old value in that cycle, new value after.
        local_addr = 4'd7;
        gpio_in = {2'b00, 1'b1, 1'b1, 8'h07, 24'h0F0F0F};
        step(7);
        check("same_cycle_old", 36'(local_rdata), 36'h0);
        step(1);
        check("same_cycle_new", 36'(local_rdata), 36'h0F0F0F);
        gpio_in[33] = 1'b0;
        step(4);
        check("same_cycle_ack_low", 36'(gpio_out[32]), 36'h0);

        // Transaction counter wraps from 0xFFFF to 0.
        @(negedge clk);
        force dut.txn_count = 16'hFFFF;
        #1;
        release dut.txn_count;
        step(1);
        check("wrap_preload", 36'(txn_count), 36'hFFFF);
        do_txn(8'h07, 1'b0, 24'h0, rd, er, wp);
        check("wrap_rdata", 36'(rd), 36'h0F0F0F);
        check("wrap_txn_count", 36'(txn_count), 36'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
